// File: rtl/smi_responder_pkg.sv
// rtl/smi_responder_pkg.sv - shared constants, header layout and FSM states for the SMI memory responder
package smi_responder_pkg;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam logic [7:0] ST_OK  = 8'h00;
    localparam logic [7:0] ST_ERR = 8'h01;

    // Bit offsets of the header fields inside a flit
    localparam int HDR_OP_LSB   = 0;
    localparam int HDR_LEN_LSB  = 8;
    localparam int HDR_TAG_LSB  = 16;
    localparam int HDR_ADDR_LSB = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        WR_DATA,
        WR_RESP,
        DRAIN,
        ERR_RESP
    } respStateT;

    // Low 32 bits of a response header; everything above is zero
    function automatic logic [31:0] respHeader(input logic [7:0] status,
                                               input logic [7:0] count,
                                               input logic [15:0] tag);
        return {tag, count, status};
    endfunction

endpackage

// File: rtl/smi_resp_skid_buffer.sv
// rtl/smi_resp_skid_buffer.sv - two-entry Ready/Stop buffer with registered outputs for the response path
module smi_resp_skid_buffer #(
    parameter int Width = 72
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    input  logic [Width-1:0] inData,
    output logic             outReady,
    output logic [Width-1:0] outData,
    input  logic             outStop,
    output logic [1:0]       count
);

    logic [Width-1:0] head;
    logic [Width-1:0] tail;
    logic [1:0]       fill;
    logic             pop;

    assign pop      = (fill != 2'd0) && !outStop;
    assign outReady = fill != 2'd0;
    assign outData  = head;
    assign count    = fill;

    // Head always presents the oldest flit; the producer never pushes into a full buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            fill <= 2'd0;
        end else begin
            case ({inValid, pop})
                2'b10: begin
                    if (fill == 2'd0) head <= inData;
                    else              tail <= inData;
                    fill <= fill + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    fill <= fill - 2'd1;
                end
                2'b11: begin
                    if (fill == 2'd1) begin
                        head <= inData;
                    end else begin
                        head <= tail;
                        tail <= inData;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/smi_memory_responder.sv
// rtl/smi_memory_responder.sv - SMI target servicing read/write frames against an internal block RAM
module smi_memory_responder
    import smi_responder_pkg::*;
#(
    parameter int FlitWidth = 8,
    parameter int AddrWidth = 10,
    parameter int DataWidth = FlitWidth * 8
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 smiReqInReady,
    input  logic [7:0]           smiReqInEofc,
    input  logic [DataWidth-1:0] smiReqInData,
    output logic                 smiReqInStop,
    output logic                 smiRespOutReady,
    output logic [7:0]           smiRespOutEofc,
    output logic [DataWidth-1:0] smiRespOutData,
    input  logic                 smiRespOutStop
);

    localparam int         ByteShift = $clog2(FlitWidth);
    localparam int         Depth     = 1 << AddrWidth;
    localparam logic [7:0] FullEofc  = 8'(FlitWidth);

    respStateT state, nextState;

    logic [AddrWidth-1:0] idx;
    logic [15:0]          tagReg;
    logic [7:0]           rdLeft;
    logic [8:0]           popLeft;
    logic [7:0]           wrCnt;
    logic                 rdValid;
    logic                 rdLastQ;

    logic [DataWidth-1:0] ram [Depth];
    logic [DataWidth-1:0] ramQ;
    logic [AddrWidth-1:0] ramAddr;
    logic                 ramRe;
    logic                 ramWe;
    logic                 rdIssueLast;
    logic [FlitWidth-1:0] byteEn;

    logic                 pushValid;
    logic [7:0]           pushEofc;
    logic [DataWidth-1:0] pushData;
    logic [1:0]           skidCount;
    logic                 pop;
    logic [2:0]           occNext;

    logic                 reqFire;
    logic                 reqLast;
    logic [7:0]           reqOp;
    logic [7:0]           reqLen;
    logic [15:0]          reqTag;
    logic [31:0]          reqAddr;
    logic [AddrWidth-1:0] reqIndex;
    logic                 hdrInRange;
    logic                 goRead;
    logic                 goWrite;

    assign reqFire    = smiReqInReady && !smiReqInStop;
    assign reqLast    = smiReqInEofc != 8'd0;
    assign reqOp      = smiReqInData[HDR_OP_LSB +: 8];
    assign reqLen     = smiReqInData[HDR_LEN_LSB +: 8];
    assign reqTag     = smiReqInData[HDR_TAG_LSB +: 16];
    assign reqAddr    = smiReqInData[HDR_ADDR_LSB +: 32];
    assign reqIndex   = reqAddr[ByteShift +: AddrWidth];
    assign hdrInRange = (reqAddr >> (ByteShift + AddrWidth)) == 32'd0;
    assign goRead     = (reqOp == OP_READ) && hdrInRange && reqLast;
    assign goWrite    = (reqOp == OP_WRITE) && hdrInRange && !reqLast;

    assign pop     = smiRespOutReady && !smiRespOutStop;
    // Buffer occupancy after this cycle, counting a RAM word landing now
    assign occNext = {1'b0, skidCount} + {2'b0, rdValid} - {2'b0, pop};

    // FSM state register
    always_ff @(posedge clk or posedge srst) begin
        if (srst) state <= IDLE;
        else      state <= nextState;
    end

    // FSM next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (reqFire) begin
                if (goRead)       nextState = RD_BURST;
                else if (goWrite) nextState = WR_DATA;
                else if (reqLast) nextState = ERR_RESP;
                else              nextState = DRAIN;
            end
            RD_BURST:          if (pop && popLeft == 9'd1) nextState = IDLE;
            WR_DATA:           if (reqFire && reqLast)     nextState = WR_RESP;
            DRAIN:             if (reqFire && reqLast)     nextState = ERR_RESP;
            WR_RESP, ERR_RESP: if (pop)                    nextState = IDLE;
            default:           nextState = IDLE;
        endcase
    end

    // FSM outputs: request backpressure, RAM strobes and response pushes
    always_comb begin
        smiReqInStop = 1'b0;
        ramRe        = 1'b0;
        ramWe        = 1'b0;
        ramAddr      = idx;
        rdIssueLast  = 1'b0;
        byteEn       = '0;
        pushValid    = 1'b0;
        pushEofc     = 8'd0;
        pushData     = '0;
        case (state)
            IDLE: if (reqFire) begin
                ramAddr = reqIndex;
                if (goRead) begin
                    // Header and first RAM read leave together so data follows one cycle later
                    ramRe       = 1'b1;
                    rdIssueLast = reqLen == 8'd0;
                    pushValid   = 1'b1;
                    pushData    = {{(DataWidth-32){1'b0}}, respHeader(ST_OK, reqLen, reqTag)};
                end else if (!goWrite && reqLast) begin
                    pushValid = 1'b1;
                    pushEofc  = FullEofc;
                    pushData  = {{(DataWidth-32){1'b0}}, respHeader(ST_ERR, 8'd0, reqTag)};
                end
            end
            RD_BURST: begin
                smiReqInStop = 1'b1;
                ramRe        = (rdLeft != 8'd0) && (occNext <= 3'd1);
                rdIssueLast  = rdLeft == 8'd1;
                pushValid    = rdValid;
                pushEofc     = rdLastQ ? FullEofc : 8'd0;
                pushData     = ramQ;
            end
            WR_DATA: if (reqFire) begin
                ramWe = 1'b1;
                for (int b = 0; b < FlitWidth; b++)
                    byteEn[b] = (smiReqInEofc == 8'd0) || (smiReqInEofc >= FullEofc) ||
                                (b < int'(smiReqInEofc));
                if (reqLast) begin
                    pushValid = 1'b1;
                    pushEofc  = FullEofc;
                    pushData  = {{(DataWidth-32){1'b0}}, respHeader(ST_OK, wrCnt, tagReg)};
                end
            end
            DRAIN: if (reqFire && reqLast) begin
                pushValid = 1'b1;
                pushEofc  = FullEofc;
                pushData  = {{(DataWidth-32){1'b0}}, respHeader(ST_ERR, 8'd0, tagReg)};
            end
            WR_RESP, ERR_RESP: smiReqInStop = 1'b1;
            default: ;
        endcase
        if (srst) smiReqInStop = 1'b1;
    end

    // Single-port RAM with byte enables and one-cycle registered read
    always_ff @(posedge clk) begin
        if (ramWe) begin
            for (int b = 0; b < FlitWidth; b++)
                if (byteEn[b]) ram[ramAddr][b*8 +: 8] <= smiReqInData[b*8 +: 8];
        end
        if (ramRe) ramQ <= ram[ramAddr];
    end

    // Transaction bookkeeping: index, tag, read credits and saturating write count
    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            idx     <= '0;
            tagReg  <= '0;
            rdLeft  <= '0;
            popLeft <= '0;
            wrCnt   <= '0;
            rdValid <= 1'b0;
            rdLastQ <= 1'b0;
        end else begin
            rdValid <= ramRe;
            rdLastQ <= ramRe && rdIssueLast;
            if (state == IDLE && reqFire) begin
                idx     <= reqIndex + AddrWidth'(goRead);
                tagReg  <= reqTag;
                rdLeft  <= reqLen;
                popLeft <= {1'b0, reqLen} + 9'd2;
                wrCnt   <= 8'd0;
            end else begin
                if (ramRe || ramWe)              idx     <= idx + AddrWidth'(1);
                if (state == RD_BURST && ramRe)  rdLeft  <= rdLeft - 8'd1;
                if (state == RD_BURST && pop)    popLeft <= popLeft - 9'd1;
                if (ramWe && wrCnt != 8'hFF)     wrCnt   <= wrCnt + 8'd1;
            end
        end
    end

    smi_resp_skid_buffer #(
        .Width(DataWidth + 8)
    ) u_skid (
        .clk     (clk),
        .rst     (srst),
        .inValid (pushValid),
        .inData  ({pushEofc, pushData}),
        .outReady(smiRespOutReady),
        .outData ({smiRespOutEofc, smiRespOutData}),
        .outStop (smiRespOutStop),
        .count   (skidCount)
    );

endmodule

// File: tb/tb_smi_memory_responder.sv
// tb/tb_smi_memory_responder.sv - self-checking bench for smi_memory_responder against a frame-level model
module tb_smi_memory_responder;

    typedef struct packed {
        logic [7:0]  eofc;
        logic [63:0] data;
    } flitT;

    localparam int Depth = 1024;

    logic        clk = 1'b0;
    logic        srst = 1'b1;
    logic        smiReqInReady = 1'b0;
    logic [7:0]  smiReqInEofc = 8'd0;
    logic [63:0] smiReqInData = 64'd0;
    logic        smiReqInStop;
    logic        smiRespOutReady;
    logic [7:0]  smiRespOutEofc;
    logic [63:0] smiRespOutData;
    logic        smiRespOutStop = 1'b1;

    int checks = 0;
    int errors = 0;
    int lastCycles = 0;
    flitT lastGot[$];
    logic [63:0] refMem [Depth];

    always #5 clk = ~clk;

    smi_memory_responder dut (
        .clk            (clk),
        .srst           (srst),
        .smiReqInReady  (smiReqInReady),
        .smiReqInEofc   (smiReqInEofc),
        .smiReqInData   (smiReqInData),
        .smiReqInStop   (smiReqInStop),
        .smiRespOutReady(smiRespOutReady),
        .smiRespOutEofc (smiRespOutEofc),
        .smiRespOutData (smiRespOutData),
        .smiRespOutStop (smiRespOutStop)
    );

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input logic [7:0] op, input logic [7:0] len,
                                        input logic [15:0] tag, input logic [31:0] addr);
        return {addr, tag, len, op};
    endfunction

    // Frame-level reference: decides the whole response and applies writes to refMem
    task automatic modelFrame(input flitT f[$], output flitT exp[$]);
        logic [63:0] h;
        logic [7:0]  op;
        logic [7:0]  len;
        logic [15:0] tag;
        int          idx;
        bit          inRange;
        int          k;
        int          cnt;
        h       = f[0].data;
        op      = h[7:0];
        len     = h[15:8];
        tag     = h[31:16];
        inRange = (h[63:32] / 8) < Depth;
        idx     = int'(h[63:32] / 8);
        exp     = {};
        if (op == 8'h01 && inRange && f.size() == 1) begin
            exp.push_back({8'd0, 32'd0, tag, len, 8'h00});
            for (int i = 0; i <= int'(len); i++)
                exp.push_back({(i == int'(len)) ? 8'd8 : 8'd0, refMem[(idx + i) % Depth]});
        end else if (op == 8'h02 && inRange && f.size() > 1) begin
            for (int i = 1; i < f.size(); i++) begin
                k = (f[i].eofc == 8'd0 || f[i].eofc >= 8'd8) ? 8 : int'(f[i].eofc);
                for (int b = 0; b < k; b++)
                    refMem[(idx + i - 1) % Depth][b*8 +: 8] = f[i].data[b*8 +: 8];
            end
            cnt = (f.size() - 2 > 255) ? 255 : f.size() - 2;
            exp.push_back({8'd8, 32'd0, tag, 8'(cnt), 8'h00});
        end else begin
            exp.push_back({8'd8, 32'd0, tag, 8'h00, 8'h01});
        end
    endtask

    task automatic sendFrame(input flitT f[$]);
        int i = 0;
        int guard = 0;
        while (i < f.size() && guard < 5000) begin
            @(negedge clk);
            smiReqInReady = 1'b1;
            {smiReqInEofc, smiReqInData} = f[i];
            if (!smiReqInStop) i++;
            guard++;
        end
        @(negedge clk);
        smiReqInReady = 1'b0;
        chk("send_done", 80'(i), 80'(f.size()));
    endtask

    // mode 0: never stall, 1: Stop pattern 1,0,0,1, 2: random Stop
    task automatic recvFrame(input int mode, output flitT got[$], output int cycles);
        bit   prevHold = 1'b0;
        flitT prevFlit = '0;
        bit   done = 1'b0;
        int   cyc = 0;
        logic stopV;
        got = {};
        while (!done && cyc < 3000) begin
            if (mode == 0)      stopV = 1'b0;
            else if (mode == 1) stopV = (cyc % 4 == 0) || (cyc % 4 == 3);
            else                stopV = 1'($urandom_range(0, 1));
            smiRespOutStop = stopV;
            if (prevHold)
                chk("hold", 80'({smiRespOutReady, smiRespOutEofc, smiRespOutData}),
                    80'({1'b1, prevFlit}));
            if (smiRespOutReady && !stopV) begin
                got.push_back({smiRespOutEofc, smiRespOutData});
                if (smiRespOutEofc != 8'd0) done = 1'b1;
            end
            prevHold = smiRespOutReady && stopV;
            prevFlit = {smiRespOutEofc, smiRespOutData};
            cyc++;
            @(negedge clk);
        end
        smiRespOutStop = 1'b1;
        cycles = cyc;
        chk("recv_done", 80'(done), 80'(1));
    endtask

    task automatic cmpFrames(input string name, input flitT got[$], input flitT exp[$]);
        chk({name, "_len"}, 80'(got.size()), 80'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s_flit%0d", name, i), 80'(got[i]), 80'(exp[i]));
    endtask

    task automatic runFrame(input string name, input flitT f[$], input int mode);
        flitT exp[$];
        flitT got[$];
        int   cyc;
        modelFrame(f, exp);
        sendFrame(f);
        chk({name, "_lat"}, 80'(smiRespOutReady), 80'(1));
        recvFrame(mode, got, cyc);
        cmpFrames(name, got, exp);
        lastCycles = cyc;
        lastGot = got;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        flitT        f[$];
        int          n;
        int          guard;
        int          rIdx;
        int          rLen;
        logic [7:0]  bv;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 80'(smiRespOutReady), 80'(0));
        chk("rst_eofc", 80'(smiRespOutEofc), 80'(0));
        chk("rst_data", 80'(smiRespOutData), 80'(0));
        chk("rst_reqstop", 80'(smiReqInStop), 80'(1));
        srst = 1'b0;
        @(negedge clk);
        chk("rel_reqstop", 80'(smiReqInStop), 80'(0));

        // Fill the whole RAM in one 1024-flit write; count field saturates at 255
        f = {};
        f.push_back({8'd0, hdr(8'h02, 8'h00, 16'h0100, 32'h0)});
        for (int i = 0; i < Depth; i++)
            f.push_back({(i == Depth - 1) ? 8'd8 : 8'd0, {$urandom, $urandom}});
        runFrame("prefill", f, 2);

        // Write burst of 4 flits then back-to-back readback
        f = {};
        f.push_back({8'd0, hdr(8'h02, 8'h00, 16'h0400, 32'h40)});
        for (int i = 0; i < 4; i++) begin
            bv = 8'(8'h11 * (i + 1));
            f.push_back({(i == 3) ? 8'd8 : 8'd0, {8{bv}}});
        end
        runFrame("wr_burst", f, 0);
        f = {};
        f.push_back({8'd1, hdr(8'h01, 8'd3, 16'h0401, 32'h40)});
        runFrame("rd_burst", f, 0);
        chk("rd_b2b_cycles", 80'(lastCycles), 80'(5));

        // Partial write with byte enables
        f = {};
        f.push_back({8'd0, hdr(8'h02, 8'h00, 16'h0500, 32'h0)});
        f.push_back({8'd8, 64'hFFFF_FFFF_FFFF_FFFF});
        runFrame("prefill_ff", f, 0);
        f = {};
        f.push_back({8'd0, hdr(8'h02, 8'h00, 16'h0501, 32'h0)});
        f.push_back({8'd3, 64'h0102_0304_0506_0708});
        runFrame("partial_wr", f, 0);
        f = {};
        f.push_back({8'd1, hdr(8'h01, 8'd0, 16'h0502, 32'h0)});
        runFrame("partial_rd", f, 0);
        if (lastGot.size() > 1)
            chk("partial_value", 80'(lastGot[1].data), 80'(64'hFFFF_FFFF_FF06_0708));

        // Backpressure on a 16-flit read with Stop 1,0,0,1 repeating
        f = {};
        f.push_back({8'd1, hdr(8'h01, 8'd15, 16'h0600, 32'h200)});
        runFrame("bp_read", f, 1);

        // Error frames: bad opcode, out-of-range write, read header not last, write header last
        f = {};
        f.push_back({8'd8, hdr(8'h07, 8'h00, 16'h0700, 32'h0)});
        runFrame("bad_op", f, 0);
        f = {};
        f.push_back({8'd0, hdr(8'h02, 8'h00, 16'h0800, 32'(Depth * 8))});
        for (int i = 0; i < 3; i++) f.push_back({(i == 2) ? 8'd8 : 8'd0, 64'hDEAD_BEEF_0000_0000 + 64'(i)});
        runFrame("oor_write", f, 2);
        f = {};
        f.push_back({8'd1, hdr(8'h01, 8'd2, 16'h0801, 32'h0)});
        runFrame("oor_check", f, 0);
        f = {};
        f.push_back({8'd0, hdr(8'h01, 8'd0, 16'h0900, 32'h8)});
        f.push_back({8'd8, 64'h1234});
        runFrame("rd_not_last", f, 2);
        f = {};
        f.push_back({8'd8, hdr(8'h02, 8'h00, 16'h0901, 32'h8)});
        runFrame("wr_last", f, 0);

        // Read that wraps past the top of the RAM
        f = {};
        f.push_back({8'd1, hdr(8'h01, 8'd3, 16'h0A00, 32'((Depth - 2) * 8))});
        runFrame("wrap_read", f, 2);

        // Randomized write/readback pairs
        for (int it = 0; it < 12; it++) begin
            rIdx = $urandom_range(0, Depth - 1);
            n    = $urandom_range(1, 6);
            f = {};
            f.push_back({8'd0, hdr(8'h02, 8'($urandom), 16'($urandom), 32'(rIdx * 8 + $urandom_range(0, 7)))});
            for (int i = 0; i < n; i++)
                f.push_back({(i == n - 1) ? 8'($urandom_range(1, 8)) : 8'd0, {$urandom, $urandom}});
            runFrame($sformatf("rnd_wr%0d", it), f, $urandom_range(0, 2));
            rLen = n - 1 + $urandom_range(0, 2);
            f = {};
            f.push_back({8'd1, hdr(8'h01, 8'(rLen), 16'($urandom), 32'(rIdx * 8))});
            runFrame($sformatf("rnd_rd%0d", it), f, $urandom_range(0, 2));
        end

        // Reset in the middle of a read burst, after header and two data flits
        f = {};
        f.push_back({8'd1, hdr(8'h01, 8'd7, 16'h0C00, 32'h100)});
        sendFrame(f);
        smiRespOutStop = 1'b0;
        n = 0;
        guard = 0;
        while (n < 3 && guard < 50) begin
            if (smiRespOutReady) n++;
            @(negedge clk);
            guard++;
        end
        chk("mid_rst_progress", 80'(n), 80'(3));
        srst = 1'b1;
        #1;
        chk("mid_rst_ready", 80'(smiRespOutReady), 80'(0));
        chk("mid_rst_eofc", 80'(smiRespOutEofc), 80'(0));
        chk("mid_rst_data", 80'(smiRespOutData), 80'(0));
        chk("mid_rst_reqstop", 80'(smiReqInStop), 80'(1));
        smiRespOutStop = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
        chk("mid_rel_reqstop", 80'(smiReqInStop), 80'(0));
        chk("mid_rel_ready", 80'(smiRespOutReady), 80'(0));
        runFrame("post_rst_read", f, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/smi_memory_responder.md
Name: smi_memory_responder

Overview:
- SMI target that terminates the downstream end of an arbitrated SMI memory bus.
- Accepts request frames on one SMI input, services them against an internal single-port block RAM, and returns response frames on one SMI output.
- Used as the far-end responder behind the scaling arbiters for simulation and for on-chip scratch memory.
- Echoes request tags verbatim, so upstream frame steering and transaction matching work unchanged.

Parameters:
- FlitWidth, 8: bytes per flit; minimum 8; data width is FlitWidth*8.
- AddrWidth, 10: RAM depth is 2^AddrWidth flits.
- DataWidth, FlitWidth*8: derived data width.

Ports:
- clk  in  1  clock.
- srst  in  1  reset; asynchronous, active-high.
- smiReqInReady  in  1  request flit valid.
- smiReqInEofc  in  8  0 = mid-frame; 1..FlitWidth = last flit, valid byte count.
- smiReqInData  in  DataWidth  request flit.
- smiReqInStop  out  1  request backpressure.
- smiRespOutReady  out  1  response flit valid.
- smiRespOutEofc  out  8  response end-of-frame/count.
- smiRespOutData  out  DataWidth  response flit.
- smiRespOutStop  in  1  response backpressure.

Behaviour:
- Flit transfer occurs on a clk edge where Ready=1 and Stop=0. Ready and Data/Eofc are held stable while Stop=1.
- Header flit (first flit of a frame) fields:
  - [7:0] opcode: 0x01 read, 0x02 write.
  - [15:8] read length-1 in flits; ignored for writes.
  - [31:16] tag; bits [31:26] carry the port ID.
  - [63:32] byte address; the flit index is addr >> log2(FlitWidth).
- Address check: a request is in range only when the flit index is less than 2^AddrWidth. Bursts increment modulo 2^AddrWidth.
- Response header fields: [7:0] status (0x00 OK, 0x01 error); [15:8] flit count-1 (0 on error); [31:16] tag echo; [63:32] zero; upper bits zero.
- Every response header-only flit and every data flit carries Eofc=FlitWidth on its last flit.
- FSM states: IDLE, RD_BURST, WR_DATA, WR_RESP, DRAIN, ERR_RESP.
  - IDLE: Stop=0.
    - Valid read header that is last flit: go to RD_BURST.
    - Valid write header that is not last: go to WR_DATA.
    - Bad opcode, out-of-range address, a read header with Eofc=0, or a write header that is last: go to DRAIN if the frame is not ended, else ERR_RESP.
  - RD_BURST: Stop=1. Emits the header, then len+1 data flits. RAM read latency is 1 cycle. A 2-entry output skid buffer with a read credit count keeps 1 flit/cycle while smiRespOutStop=0 and never drops or duplicates a flit under any Stop pattern. Goes to IDLE after the last data flit transfers.
  - WR_DATA: Stop=0. Each accepted flit writes the RAM at the current index.
    - Eofc=0 or FlitWidth: full-flit write.
    - Eofc=k (1..FlitWidth-1): byte-enables for the low k bytes only.
    - The Eofc!=0 flit goes to WR_RESP.
    - Count exceeding 256 flits: remaining flits are still written (wrapping), the count field saturates at 255, and status is OK.
  - WR_RESP: Stop=1. Emits one flit with status OK and count-1, then goes to IDLE.
  - DRAIN: Stop=0. Discards flits until Eofc!=0, then goes to ERR_RESP.
  - ERR_RESP: Stop=1. Emits one error flit, then goes to IDLE.
- Latency:
  - Read: header Ready the cycle after the request flit is accepted; data flit i Ready by cycle T+2+i when Stop=0.
  - Write: response Ready the cycle after the last flit is accepted.
- Only one transaction is in flight; requests are serviced in arrival order.
- Reset (async, any state, including mid-burst):
  - FSM goes to IDLE; skid buffer and credits are cleared.
  - smiRespOutReady=0, smiRespOutEofc=0, smiRespOutData=0.
  - smiReqInStop=1 while srst is high, then 0 in the first cycle after release.
  - RAM contents are not reset; a partially emitted frame is abandoned.

Decomposition:
- Package smi_responder_pkg: opcode constants (OP_READ, OP_WRITE), status constants (ST_OK, ST_ERR), header field bit offsets, FSM state enum.
- Sub-module smi_resp_skid_buffer: 2-entry Ready/Stop buffer on the response path. The RAM is inferred inline.

Test Plan:
- Write burst: header op=0x02, tag=0x0400, addr=0x40, then 4 flits 0x11..11..0x44..44 with last Eofc=8 -> one response flit, status 0x00, count 3, tag 0x0400, Eofc=8. Follow with read addr=0x40, len=3 -> header plus 4 flits equal to the written data, back-to-back at 1 flit/cycle.
- Partial write: prefill index 0 with all 0xFF; write one data flit 0x0102030405060708 with Eofc=3 -> readback 0xFFFFFFFFFF060708.
- Backpressure: read len=15 with smiRespOutStop toggling 1,0,0,1 repeating -> exactly 16 data flits in address order, no loss or duplicates, Data stable while Stop=1.
- Errors: op=0x07 single-flit frame -> one flit status 0x01, count 0. Write with addr=2^AddrWidth*FlitWidth and 3 data flits -> flits drained, one error flit, RAM unchanged.
- Wrap: read addr=(2^AddrWidth-2)*FlitWidth, len=3 -> data from indices 2^AddrWidth-2, 2^AddrWidth-1, 0, 1.
- Reset mid read burst after 2 data flits -> smiRespOutReady=0 immediately. After release, a new read of the same range completes with correct data.
